// File: rtl/huc6260_pkg.sv
// Shared timing constants, dot-clock select encoding and divisor decode
// for the HuC6260 video timing generator.
package huc6260_pkg;

  localparam int DEF_LINE_CLKS   = 1365;
  localparam int DEF_FRAME_LINES = 263;
  localparam int DEF_HS_CLKS     = 100;
  localparam int DEF_HB_START    = 1140;
  localparam int DEF_VB_START    = 240;
  localparam int DEF_VS_START    = 247;
  localparam int DEF_VS_LINES    = 3;

  typedef enum logic [1:0] {
    DOT_DIV4 = 2'd0,
    DOT_DIV3 = 2'd1,
    DOT_DIV2 = 2'd2
  } dotclk_sel_t;

  // Encoding 3 is not named; it behaves as divide-by-2.
  function automatic logic [2:0] dsel_decode(input dotclk_sel_t sel);
    case (sel)
      DOT_DIV4: dsel_decode = 3'd4;
      DOT_DIV3: dsel_decode = 3'd3;
      default:  dsel_decode = 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/huc6260_dotdiv.sv
// Dot-clock divider: phase counter, latched divisor and PCE generation.
// The divisor is only re-latched at the frame restart so a mid-frame
// select change cannot produce a line with mixed dot widths.
module huc6260_dotdiv
  import huc6260_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic [1:0] dotclk_sel,
  input  logic       line_restart,
  input  logic       frame_restart,
  output logic       pce
);

  logic [1:0] div;
  logic [2:0] dsel;

  // Divider phase and divisor latch; every line restarts on a dot boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div  <= 2'd0;
      dsel <= 3'd4;
    end else if (ce) begin
      if (line_restart) begin
        div <= 2'd0;
        if (frame_restart) begin
          dsel <= dsel_decode(dotclk_sel_t'(dotclk_sel));
        end
      end else if ({1'b0, div} == dsel - 3'd1) begin
        div <= 2'd0;
      end else begin
        div <= div + 2'd1;
      end
    end
  end

  // Same-cycle dot enable so the consumer sees ROW/COL alongside it.
  assign pce = ce & (div == 2'd0) & ~rst;

endmodule

// File: rtl/huc6260_timing.sv
// HuC6260 video timing generator: master-clock line position, dot column,
// row counter and decoded sync/blank strobes.
module huc6260_timing
  import huc6260_pkg::*;
#(
  parameter int LINE_CLKS   = DEF_LINE_CLKS,
  parameter int FRAME_LINES = DEF_FRAME_LINES,
  parameter int HS_CLKS     = DEF_HS_CLKS,
  parameter int HB_START    = DEF_HB_START,
  parameter int VB_START    = DEF_VB_START,
  parameter int VS_START    = DEF_VS_START,
  parameter int VS_LINES    = DEF_VS_LINES
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       CE,
  input  logic [1:0] DOTCLK_SEL,
  output logic       PCE,
  output logic [8:0] ROW,
  output logic [8:0] COL,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       HBLANK,
  output logic       VBLANK
);

  logic [10:0] mclk;
  logic [8:0]  row;
  logic [8:0]  col;
  logic        line_end;
  logic        frame_end;
  logic        pce;

  assign line_end  = (mclk == 11'(LINE_CLKS - 1));
  assign frame_end = line_end && (row == 9'(FRAME_LINES - 1));

  huc6260_dotdiv u_dotdiv (
    .clk           (CLK),
    .rst           (RES),
    .ce            (CE),
    .dotclk_sel    (DOTCLK_SEL),
    .line_restart  (line_end),
    .frame_restart (frame_end),
    .pce           (pce)
  );

  // Line position, row and dot column; COL saturates rather than wrapping
  // so divide-by-2 lines never alias back onto early columns.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      mclk <= 11'd0;
      row  <= 9'd0;
      col  <= 9'd0;
    end else if (CE) begin
      if (line_end) begin
        mclk <= 11'd0;
        col  <= 9'd0;
        row  <= frame_end ? 9'd0 : row + 9'd1;
      end else begin
        mclk <= mclk + 11'd1;
        if (pce && (col != 9'd511)) begin
          col <= col + 9'd1;
        end
      end
    end
  end

  // Strobes decode straight from registered position, no CE gating.
  always_comb begin
    HSYNC  = (mclk < 11'(HS_CLKS));
    HBLANK = (mclk >= 11'(HB_START));
    VBLANK = (row >= 9'(VB_START));
    VSYNC  = (row >= 9'(VS_START)) && (row < 9'(VS_START + VS_LINES));
  end

  assign PCE = pce;
  assign ROW = row;
  assign COL = col;

endmodule

// File: tb/tb_huc6260_timing.sv
// Directed bench for huc6260_timing. Line timing uses the real 1365-clock
// line; the frame is shortened to 10 rows so several full frames fit in a
// short run. Rows: vblank from 6, vsync on 7..8, interrupt point row 5 col 0.
module tb_huc6260_timing;

  localparam int LCLK   = 1365;
  localparam int FLINES = 10;
  localparam int VBS    = 6;
  localparam int VSS    = 7;
  localparam int VSL    = 2;
  localparam int IRQ_ROW = VBS - 1;

  logic       clk = 1'b0;
  logic       res;
  logic       ce;
  logic [1:0] sel;
  logic       pce;
  logic [8:0] row;
  logic [8:0] col;
  logic       hsync, vsync, hblank, vblank;

  int checks = 0;
  int errors = 0;
  int irq_count = 0;

  huc6260_timing #(
    .FRAME_LINES (FLINES),
    .VB_START    (VBS),
    .VS_START    (VSS),
    .VS_LINES    (VSL)
  ) dut (
    .CLK        (clk),
    .RES        (res),
    .CE         (ce),
    .DOTCLK_SEL (sel),
    .PCE        (pce),
    .ROW        (row),
    .COL        (col),
    .HSYNC      (hsync),
    .VSYNC      (vsync),
    .HBLANK     (hblank),
    .VBLANK     (vblank)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks one full line from mclk 0 with CE=1, comparing every cycle
  // against the expected dot pattern and strobe decode for row erow.
  task automatic line_check(input int d, input int erow, input string tag);
    int pulses, last_col, pos_err, col_err, dec_err, exp_pulses, exp_last;
    pulses = 0; last_col = -1; pos_err = 0; col_err = 0; dec_err = 0;
    for (int m = 0; m < LCLK; m++) begin
      if (pce) begin
        pulses++;
        last_col = int'(col);
        if (int'(col) != ((pulses - 1) > 511 ? 511 : pulses - 1)) col_err++;
        if (int'(row) == IRQ_ROW && col == 9'd0) irq_count++;
      end
      if (pce !== ((m % d) == 0)) pos_err++;
      if (int'(row) != erow) dec_err++;
      if (hsync  !== (m < 100))   dec_err++;
      if (hblank !== (m >= 1140)) dec_err++;
      if (vblank !== (erow >= VBS)) dec_err++;
      if (vsync  !== (erow >= VSS && erow < VSS + VSL)) dec_err++;
      tick();
    end
    exp_pulses = (LCLK + d - 1) / d;
    exp_last   = (exp_pulses - 1) > 511 ? 511 : exp_pulses - 1;
    check({tag, "_pulses"},   pulses,   exp_pulses);
    check({tag, "_last_col"}, last_col, exp_last);
    check({tag, "_pce_pos"},  pos_err,  0);
    check({tag, "_col_seq"},  col_err,  0);
    check({tag, "_decode"},   dec_err,  0);
  endtask

  initial begin
    res = 1'b1; ce = 1'b1; sel = 2'd0;
    #2;
    check("rst_pce",    pce,    0);
    check("rst_row",    row,    0);
    check("rst_col",    col,    0);
    check("rst_hsync",  hsync,  1);
    check("rst_hblank", hblank, 0);
    check("rst_vsync",  vsync,  0);
    check("rst_vblank", vblank, 0);

    @(negedge clk);
    res = 1'b0;
    #1;
    check("first_pce",   pce,   1);
    check("first_col",   col,   0);
    check("first_row",   row,   0);
    check("first_hsync", hsync, 1);

    line_check(4, 0, "div4_r0");
    check("nl_row", row, 1);
    check("nl_col", col, 0);
    check("nl_pce", pce, 1);

    // Switch to div 3 mid-frame: remaining rows must stay div 4.
    sel = 2'd1;
    for (int r = 1; r < FLINES; r++) line_check(4, r, "div4_hold");
    check("irq_frame1", irq_count, 1);
    check("wrap_row", row, 0);

    line_check(3, 0, "div3_r0");
    sel = 2'd2;
    for (int r = 1; r < FLINES; r++) line_check(3, r, "div3_hold");
    check("irq_frame2", irq_count, 2);

    line_check(2, 0, "div2_r0");
    check("div2_next_row", row, 1);

    // CE gating: state holds and PCE stays low while CE=0.
    ce = 1'b0; #1;
    check("ce0_pce", pce, 0);
    tick(); tick(); tick();
    check("ce0_hold_col", col, 0);
    check("ce0_hold_row", row, 1);
    check("ce0_pce2",     pce, 0);
    ce = 1'b1; #1;
    check("ce1_pce", pce, 1);
    tick();
    check("ce1_col", col, 1);
    check("ce1_pce_off", pce, 0);
    ce = 1'b0;
    tick(); tick();
    check("ce0_col_hold2", col, 1);
    ce = 1'b1; #1;
    check("ce1_pce_div1", pce, 0);
    tick();
    check("ce1_pce_div0", pce, 1);
    check("ce1_col_still", col, 1);
    tick();
    check("ce1_col_adv", col, 2);

    // Asynchronous reset between edges.
    #2;
    res = 1'b1;
    #1;
    check("arst_row",   row,   0);
    check("arst_col",   col,   0);
    check("arst_pce",   pce,   0);
    check("arst_hsync", hsync, 1);
    @(negedge clk);
    res = 1'b0;
    #1;
    check("arel_pce", pce, 1);
    check("arel_row", row, 0);
    // Divisor returns to 4 after reset even though DOTCLK_SEL is still 2.
    line_check(4, 0, "arel_div4");
    check("arel_next_row", row, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/huc6260_timing.md
Name: huc6260_timing

Overview:
- Video timing generator for the HuC6260 VCE side of the video path.
- Divides the master clock into the pixel clock and counts dots and lines.
- Drives PCE, ROW and COL into the HuC6270, which raises its vertical-blank interrupt at ROW 239 / COL 0.
- Also produces sync and blanking strobes for the video output stage.

Parameters:
- LINE_CLKS, 1365: master-clock (CE) cycles per scanline.
- FRAME_LINES, 263: scanlines per frame. ROW runs 0..FRAME_LINES-1.
- HS_CLKS, 100: HSYNC width in master clocks, starting at line start.
- HB_START, 1140: first master clock of horizontal blanking. Blank lasts to end of line.
- VB_START, 240: first blanked row. Blank lasts to end of frame.
- VS_START, 247: first VSYNC row.
- VS_LINES, 3: VSYNC height in rows.

Ports:
- CLK  in  1  system clock
- RES  in  1  reset, asynchronous, active-high
- CE  in  1  master-clock enable (21.477 MHz rate). All state advances only when CE=1.
- DOTCLK_SEL  in  2  dot-clock select: 0 = div 4, 1 = div 3, 2/3 = div 2
- PCE  out  1  dot enable to HuC6270
- ROW  out  9  current line
- COL  out  9  current dot within line
- HSYNC  out  1  active-high
- VSYNC  out  1  active-high
- HBLANK  out  1  active-high
- VBLANK  out  1  active-high

Behaviour:
- Internal registered state:
  - mclk[10:0]: master-clock position in the line.
  - div[1:0]: dot-divider phase.
  - dsel: latched divisor, 2..4.
  - COL, ROW.
- Reset (async, RES=1): mclk=0, div=0, COL=0, ROW=0, dsel=4 (DOTCLK_SEL is ignored while RES=1).
  - Reset outputs: PCE=0, HSYNC=1 (mclk 0 < HS_CLKS), HBLANK=0, VSYNC=0, VBLANK=0.
- PCE = CE & (div==0) & ~RES. It is combinational from registered state, so the consumer sees it in the same CE cycle. COL and ROW are valid while PCE=1.
- On each CE cycle (RES=0):
  - End of line (mclk == LINE_CLKS-1):
    - mclk<=0, div<=0, COL<=0.
    - ROW <= (ROW==FRAME_LINES-1) ? 0 : ROW+1.
    - If ROW wraps, dsel <= decode(DOTCLK_SEL).
  - Otherwise:
    - mclk<=mclk+1.
    - div <= (div==dsel-1) ? 0 : div+1.
    - If PCE, COL <= (COL==511) ? 511 : COL+1. COL saturates and does not wrap.
- CE=0: all state holds. PCE=0.
- Every line begins with a dot (div forced to 0). A trailing partial dot is truncated.
- Dot counts per line:
  - div 4: 342 dots (COL 0..341).
  - div 3: 455 dots (COL 0..454).
  - div 2: 683 PCE pulses; COL holds at 511 for pulses 512..682.
- DOTCLK_SEL changes mid-frame have no effect until the ROW wrap to 0. The new divisor applies starting with the first dot of row 0.
- Decoded outputs come from registered mclk/ROW, with zero added latency and no CE gating:
  - HSYNC = mclk < HS_CLKS
  - HBLANK = mclk >= HB_START
  - VBLANK = ROW >= VB_START
  - VSYNC = VS_START <= ROW < VS_START+VS_LINES
- Reset mid-line: all counters clear immediately and asynchronously. Timing restarts from mclk 0 / row 0 on the first CE after release.
- Widths: mclk 11 bits (LINE_CLKS ≤ 2048). ROW 9 bits (FRAME_LINES ≤ 512). Compares are unsigned.

Decomposition:
- Package huc6260_pkg holds:
  - Default timing constants (LINE_CLKS, FRAME_LINES, blank/sync positions).
  - Typedef dotclk_sel_t with enum DOT_DIV4/DOT_DIV3/DOT_DIV2.
  - Function dsel_decode(dotclk_sel_t) returning the divisor.
- Optional sub-module huc6260_dotdiv: the div counter, dsel latch and PCE generation. Inputs are a line-restart strobe and a frame-restart strobe.
- Line and frame counters stay in the top module.

Test Plan:
- Reset, then CE held 1 → first cycle after release: PCE=1, COL=0, ROW=0, HSYNC=1. At mclk=100, HSYNC=0. At mclk=1140, HBLANK=1.
- DOTCLK_SEL=0 over one full line → exactly 342 PCE pulses at mclk 0,4,…,1364. COL on the last pulse = 341. Next line first pulse has COL=0, ROW=1.
- DOTCLK_SEL=1 applied mid-frame → still 342 dots/line until ROW wraps 262→0. Then 455 dots/line; last COL = 454.
- DOTCLK_SEL=2 → 683 pulses per line. COL reaches 511 at pulse 512 and stays 511 through pulse 683.
- Run a full frame → ROW 239, COL 0 occurs with PCE=1 exactly once per frame. VBLANK rises at ROW 240. VSYNC is high for ROW 247..249. ROW wraps 262→0 after 263×1365 CE cycles.
- CE toggling 1/0 → state advances only on CE=1 cycles and PCE never asserts while CE=0. RES pulsed asynchronously mid-line (between clock edges) → ROW/COL read 0 before the next CLK edge. Timing restarts cleanly after release.
